// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    // Receiver FSM states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_rx_state_e;

    // 8N1 framing: eight data bits per frame.
    localparam int UART_DATA_BITS = 8;

    // System clocks per serial bit (integer division, rounds down).
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Downstream byte stream plus error pulses leaving the UART receiver.
//
// Handshake: DATA is meaningful only while VALID=1. A byte is transferred
// on a rising edge where VALID && READY; until then DATA and VALID hold.
// READY has no effect while VALID=0. VALID never waits on READY.
// FRAME_ERR and OVERRUN are single-cycle pulses, never high together.
interface uart_rx_if;

    logic [uart_pkg::UART_DATA_BITS-1:0] DATA;
    logic                                VALID;
    logic                                READY;
    logic                                FRAME_ERR;
    logic                                OVERRUN;

    // Receiver side: produces bytes and error pulses.
    modport master (
        output DATA,
        output VALID,
        output FRAME_ERR,
        output OVERRUN,
        input  READY
    );

    // Consumer side: takes bytes, observes error pulses.
    modport slave (
        input  DATA,
        input  VALID,
        input  FRAME_ERR,
        input  OVERRUN,
        output READY
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive buffer. Head data and valid come straight from flops
// (storage, read pointer, count), so a push is visible the next cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A pop is only real when something is there; a simultaneous pop frees
    // the slot a push into a full buffer needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head  = mem[rd_ptr];
    assign valid = !empty;

    // Storage, pointers and occupancy; everything clears on reset so the
    // head reads as zero while empty after reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: RXD synchroniser, mid-bit sampling FSM with a baud
// down-counter, and a small buffer offering bytes over valid/ready.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic           CLK,
    input  logic           RESETN,
    input  logic           RXD,
    uart_rx_if.master      bus,
    output uart_rx_state_e dbg_state
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(UART_DATA_BITS);

    // Half-bit reload lands the first tick in the middle of the start bit;
    // full-bit reloads keep every later tick mid-bit.
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_baud_chk
        $error("uart_rx: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
    end

    logic [1:0]                sync_q;
    logic                      rxd_s;
    uart_rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tick;
    logic                      push;
    logic                      frame_err;
    logic                      fifo_full;
    logic                      fifo_valid;
    logic [UART_DATA_BITS-1:0] fifo_head;

    assign rxd_s = sync_q[1];
    assign tick  = (cnt_q == '0);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RXD};
        end
    end

    // FSM state, baud counter, bit index and shift register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: sample on each tick, push good bytes, flag bad stops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = tick ? FULL_RELOAD : cnt_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (!rxd_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        // Start bit did not survive to mid-bit: a glitch.
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rxd_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line returns high so a break is one error.
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .push      (push),
        .push_data (shift_q),
        .full      (fifo_full),
        .pop       (bus.READY),
        .head      (fifo_head),
        .valid     (fifo_valid)
    );

    assign bus.DATA      = fifo_head;
    assign bus.VALID     = fifo_valid;
    assign bus.FRAME_ERR = frame_err;
    // Byte lost only when the buffer is full and nothing leaves this cycle.
    assign bus.OVERRUN   = push && fifo_full && !(bus.READY && fifo_valid);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a byte scoreboard and error-pulse monitor.
module tb_uart_rx;
    import uart_pkg::*;

    logic           CLK;
    logic           RESETN;
    logic           RXD;
    uart_rx_state_e dbg_state;

    uart_rx_if bus();

    uart_rx #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD_RATE   (100_000),
        .FIFO_DEPTH  (4)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .RXD       (RXD),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset block: 10 time-unit period, posedge at multiples of 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard and counters.
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int valid_samples;
    int first_valid_cyc;
    int pops;
    int first_pop_cyc;
    int last_pop_cyc;
    int fe_cnt;
    int ov_cnt;
    int ov_cyc;
    int frame_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        valid_samples   = 0;
        first_valid_cyc = -1;
        pops            = 0;
        first_pop_cyc   = -1;
        last_pop_cyc    = -1;
        fe_cnt          = 0;
        ov_cnt          = 0;
        ov_cyc          = -1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Driver: one 8N1 frame, 16 clocks per bit, changes on negedges.
    // ready_at raises READY at that cycle of the frame; stop_after truncates.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int ready_at, input int stop_after);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int c = 0; c < 160 && c < stop_after; c++) begin
            @(negedge CLK);
            if (c == 0) frame_cyc = cyc;
            RXD = bits[c / 16];
            if (c == ready_at) bus.READY = 1'b1;
        end
    endtask

    // Monitor: samples one time unit before each rising edge.
    always @(negedge CLK) begin
        #4;
        if (RESETN) begin
            if (bus.VALID) begin
                valid_samples++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (bus.VALID && bus.READY) begin
                pops++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rx_data", 32'(bus.DATA), 32'(exp_q.pop_front()));
            end
            if (bus.FRAME_ERR || bus.OVERRUN)
                check("err_exclusive", 32'(bus.FRAME_ERR && bus.OVERRUN), 32'd0);
            if (bus.FRAME_ERR) fe_cnt++;
            if (bus.OVERRUN) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        frame_cyc = 0;
        RESETN    = 1'b0;
        RXD       = 1'b1;
        bus.READY = 1'b0;
        wait_cycles(3);
        check("rst_data",      32'(bus.DATA),      32'd0);
        check("rst_valid",     32'(bus.VALID),     32'd0);
        check("rst_frame_err", 32'(bus.FRAME_ERR), 32'd0);
        check("rst_overrun",   32'(bus.OVERRUN),   32'd0);
        check("rst_state",     32'(dbg_state),     32'(IDLE));
        RESETN = 1'b1;
        wait_cycles(5);

        // Single frame 0xA5, latency from start edge to VALID.
        clear_mon();
        bus.READY = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, 160);
        wait_cycles(10);
        check("lat_valid_cycle", 32'(first_valid_cyc - frame_cyc), 32'd155);
        check("lat_valid_once",  32'(valid_samples), 32'd1);
        check("lat_pops",        32'(pops), 32'd1);
        check("lat_no_fe",       32'(fe_cnt), 32'd0);
        check("lat_no_ov",       32'(ov_cnt), 32'd0);

        // Glitch on the line shorter than half a bit.
        clear_mon();
        @(negedge CLK) RXD = 1'b0;
        wait_cycles(4);
        check("glitch_in_start", 32'(dbg_state), 32'(START));
        RXD = 1'b1;
        wait_cycles(20);
        check("glitch_idle",  32'(dbg_state), 32'(IDLE));
        check("glitch_valid", 32'(valid_samples), 32'd0);
        check("glitch_fe",    32'(fe_cnt), 32'd0);
        check("glitch_ov",    32'(ov_cnt), 32'd0);

        // Framing error followed by a break, then a good frame.
        clear_mon();
        send_frame(8'h3C, 1'b0, -1, 160);
        RXD = 1'b0;
        wait_cycles(40);
        check("break_wait_idle", 32'(dbg_state), 32'(WAIT_IDLE));
        check("fe_pulse_once",   32'(fe_cnt), 32'd1);
        check("fe_no_byte",      32'(valid_samples), 32'd0);
        RXD = 1'b1;
        wait_cycles(20);
        check("fe_back_idle", 32'(dbg_state), 32'(IDLE));
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, 160);
        wait_cycles(5);
        check("fe_next_pops",  32'(pops), 32'd1);
        check("fe_next_fe",    32'(fe_cnt), 32'd1);
        check("fe_next_ov",    32'(ov_cnt), 32'd0);

        // Overrun: five bytes into a four-entry buffer with READY low.
        clear_mon();
        bus.READY = 1'b0;
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, 160);
        check("ov_pulse_once", 32'(ov_cnt), 32'd1);
        check("ov_at_stop",    32'(ov_cyc - frame_cyc), 32'd154);
        check("ov_held_valid", 32'(bus.VALID), 32'd1);
        check("ov_head",       32'(bus.DATA), 32'h01);
        @(negedge CLK) bus.READY = 1'b1;
        wait_cycles(8);
        check("ov_drain_pops",  32'(pops), 32'd4);
        check("ov_drain_run",   32'(last_pop_cyc - first_pop_cyc), 32'd3);
        check("ov_drain_empty", 32'(bus.VALID), 32'd0);
        check("ov_q_empty",     32'(exp_q.size()), 32'd0);

        // Full buffer with a pop in the same cycle as the fifth push.
        clear_mon();
        bus.READY = 1'b0;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1, 160);
        send_frame(8'h05, 1'b1, 154, 160);
        wait_cycles(10);
        check("full_pop_no_ov",  32'(ov_cnt), 32'd0);
        check("full_pop_pops",   32'(pops), 32'd5);
        check("full_pop_q",      32'(exp_q.size()), 32'd0);
        check("full_pop_empty",  32'(bus.VALID), 32'd0);

        // Reset in the middle of a frame with two bytes buffered.
        clear_mon();
        bus.READY = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, -1, 160);
        send_frame(8'h22, 1'b1, -1, 160);
        send_frame(8'h77, 1'b1, -1, 60);
        check("mid_data_state", 32'(dbg_state), 32'(DATA));
        check("mid_buffered",   32'(bus.VALID), 32'd1);
        @(negedge CLK);
        RESETN = 1'b0;
        RXD    = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.VALID), 32'd0);
        check("midrst_data",  32'(bus.DATA),  32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        exp_q.delete();
        @(negedge CLK) RESETN = 1'b1;
        wait_cycles(10);
        clear_mon();
        bus.READY = 1'b1;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, -1, 160);
        wait_cycles(5);
        check("post_rst_pops",  32'(pops), 32'd1);
        check("post_rst_once",  32'(valid_samples), 32'd1);
        check("post_rst_q",     32'(exp_q.size()), 32'd0);
        check("post_rst_no_fe", 32'(fe_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that sits between the SoC's RXD pin and the memory-mapped I/O block the CPU reads. It deserialises 8N1 frames from the asynchronous RXD line and samples each bit at mid-bit using a clock-divider counter. Received bytes are buffered in a small FIFO and offered downstream over a valid/ready handshake. It flags framing errors and overruns.

Parameters:
CLK_FREQ_HZ, 12_000_000, system clock frequency.
BAUD_RATE, 115_200, line bit rate.
CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE, derived localparam (integer division); elaboration error if < 4.
FIFO_DEPTH, 4, receive buffer entries; must be a power of 2, ≥ 2.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RESETN  input  1  asynchronous, active-low reset.
RXD  input  1  serial line, asynchronous to CLK, idles high.
DATA  output  8  byte at FIFO head; valid only while VALID=1.
VALID  output  1  FIFO non-empty.
READY  input  1  consumer accepts DATA when VALID&&READY at a rising edge.
FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
OVERRUN  output  1  one-cycle pulse: completed byte dropped because FIFO full.

Behaviour:
- Reset (RESETN=0, async): sync flops=1, state=IDLE, counters=0, FIFO empty; DATA=0, VALID=0, FRAME_ERR=0, OVERRUN=0.
- RXD passes through a 2-flop synchroniser (reset value 1); the FSM sees only rxd_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: rxd_s==0 -> START, baud_cnt=CLKS_PER_BIT/2-1.
- Each non-IDLE cycle: baud_cnt decrements; "tick" is the cycle baud_cnt==0, which reloads CLKS_PER_BIT-1.
- START tick: rxd_s==0 -> DATA, bit_idx=0; rxd_s==1 -> IDLE (glitch rejected, nothing reported).
- DATA tick: shift_reg = {rxd_s, shift_reg[7:1]} (LSB first), bit_idx++; after the 8th sample -> STOP.
- STOP tick, rxd_s==1: byte pushed into FIFO -> IDLE. If FIFO full with no pop that cycle, byte dropped, OVERRUN=1 for that cycle.
- STOP tick, rxd_s==0: byte discarded, FRAME_ERR=1 for that cycle -> WAIT_IDLE.
- WAIT_IDLE: stays until rxd_s==1 -> IDLE. Prevents a break condition from being read as repeated frames.
- FIFO: push and pop in the same cycle are both honoured, including when full (counts as not full) and when empty (pop ignored since VALID=0).
- No fall-through: a byte pushed in cycle N gives VALID=1 from cycle N+1.
- DATA/VALID are registered outputs from FIFO head and count. DATA holds its value while VALID&&!READY.
- Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
- End-to-end latency, falling start edge on RXD to VALID: 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
- FRAME_ERR and OVERRUN are never asserted together.
- RESETN asserted mid-frame: partial byte lost, FIFO contents lost.
- READY is ignored while VALID=0.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_e {IDLE, START, DATA, STOP, WAIT_IDLE};
  - localparam UART_DATA_BITS=8;
  - function clks_per_bit(clk_hz, baud).
- One sub-module, uart_rx_fifo, parameterised by WIDTH and DEPTH. It carries push/full/pop/empty and the head-data interface, with the same CLK/RESETN.
- The FSM, synchroniser and baud counter live in uart_rx.

Test Plan:
- Parameters for all scenarios: CLK_FREQ_HZ=1_600_000, BAUD_RATE=100_000 (CLKS_PER_BIT=16), FIFO_DEPTH=4.
- Single frame 0xA5, READY=1 -> exactly one cycle VALID=1 with DATA=0xA5, 2+8+144+1=155 cycles after the start edge; no error pulses.
- Glitch: RXD low for 4 cycles, then high -> FSM returns to IDLE; VALID, FRAME_ERR, OVERRUN stay 0.
- Frame 0x3C with stop bit forced low, RXD held low 40 more cycles, then high, then frame 0x81 -> one FRAME_ERR pulse; 0x3C never appears; 0x81 received correctly after the line returns high.
- READY=0; send 0x01..0x05 back to back -> 0x01..0x04 buffered, one OVERRUN pulse at 0x05's stop tick. Then READY=1 -> DATA sequence 0x01,0x02,0x03,0x04 on consecutive cycles, then VALID=0.
- FIFO full with READY=1 asserted in the same cycle as the 5th byte's stop tick -> no OVERRUN; 0x05 is retained and delivered after 0x04.
- RESETN pulsed low mid-DATA of frame 0x77 with 2 bytes buffered -> VALID=0, DATA=0 immediately. A following frame 0x42 is received cleanly as the only byte.
